// File: rtl/cdb_arbiter.sv
// Four-source CDB arbiter: per-source {tag,data} FIFOs with round-robin grant onto one broadcast bus.
// One-cycle latency from push to broadcast; src_ready reflects registered FIFO occupancy only.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [3:0]            src_valid,
    input  logic [4*TAG_W-1:0]    src_tag,
    input  logic [4*DATA_W-1:0]   src_data,
    output logic [3:0]            src_ready,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [DATA_W-1:0]     cdb_data,
    output logic [1:0]            cdb_src
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + DATA_W;

    typedef logic [EW-1:0] entry_t;

    entry_t         mem    [4][DEPTH];
    logic [CW-1:0]  count  [4];
    logic [PW-1:0]  rd_ptr [4];
    logic [PW-1:0]  wr_ptr [4];
    logic [1:0]     rr_ptr;

    logic           gnt;
    logic [1:0]     gnt_idx;
    logic [3:0]     push;
    logic [3:0]     pop;
    entry_t         head;

    // Ready depends only on registered count, so a full FIFO cannot accept even while popping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_ready[i] = count[i] < CW'(DEPTH);
            push[i]      = src_valid[i] && src_ready[i] && !flush;
        end
    end

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!gnt && count[rr_ptr + 2'(k)] != '0) begin
                gnt     = 1'b1;
                gnt_idx = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (gnt && !flush) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    assign head = mem[gnt_idx][rd_ptr[gnt_idx]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            // Flush drops everything in flight but keeps the fairness pointer.
            for (int i = 0; i < 4; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
            cdb_valid <= gnt;
            if (gnt) begin
                cdb_tag  <= head[EW-1 -: TAG_W];
                cdb_data <= head[DATA_W-1:0];
                cdb_src  <= gnt_idx;
                rr_ptr   <= gnt_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-source ordering scoreboard.
module tb_cdb_arbiter;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [3:0]         vld;
    logic [5:0]         tg [4];
    logic [31:0]        dt [4];
    logic [3:0]         src_ready;
    logic               cdb_valid;
    logic [5:0]         cdb_tag;
    logic [31:0]        cdb_data;
    logic [1:0]         cdb_src;

    int                 checks;
    int                 failures;
    logic [37:0]        q [4][$];
    logic               bc_vld;
    logic [1:0]         bc_src;

    cdb_arbiter #(.DATA_W(32), .TAG_W(6), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (vld),
        .src_tag   ({tg[3], tg[2], tg[1], tg[0]}),
        .src_data  ({dt[3], dt[2], dt[1], dt[0]}),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) q[i].delete();
    endtask

    // One clock: record accepted pushes, then check any broadcast against the per-source queue.
    task automatic step();
        logic [3:0]  rdy;
        logic [3:0]  v;
        logic        fl;
        logic [37:0] e;
        rdy = src_ready;
        v   = vld;
        fl  = flush;
        @(posedge clk);
        #1;
        if (fl) begin
            clear_q();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (v[i] && rdy[i]) begin
                    q[i].push_back({tg[i], dt[i]});
                    tg[i] = tg[i] + 6'd1;
                    dt[i] = dt[i] + 32'd1;
                end
            end
        end
        bc_vld = cdb_valid;
        bc_src = cdb_src;
        if (cdb_valid === 1'b1) begin
            chk("sb_nonempty", 64'(q[cdb_src].size() != 0), 64'd1);
            if (q[cdb_src].size() != 0) begin
                e = q[cdb_src].pop_front();
                chk("sb_tag", 64'(cdb_tag), 64'(e[37:32]));
                chk("sb_data", 64'(cdb_data), 64'(e[31:0]));
            end
        end
    endtask

    initial begin
        logic [1:0] prev;
        checks   = 0;
        failures = 0;
        flush    = 1'b0;
        vld      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tg[i] = '0;
            dt[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(src_ready), 64'hf);
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_data", 64'(cdb_data), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        rst = 1'b0;

        // Single result on source 0
        vld = 4'b0001; tg[0] = 6'h05; dt[0] = 32'hDEAD_BEEF;
        step();
        vld = 4'b0000;
        chk("single_no_bypass", 64'(cdb_valid), 64'd0);
        step();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_tag", 64'(cdb_tag), 64'h05);
        chk("single_data", 64'(cdb_data), 64'hDEAD_BEEF);
        chk("single_src", 64'(cdb_src), 64'd0);
        step();
        chk("single_idle", 64'(cdb_valid), 64'd0);
        chk("single_hold_tag", 64'(cdb_tag), 64'h05);
        chk("single_hold_data", 64'(cdb_data), 64'hDEAD_BEEF);

        // Single result on source 3 realigns rr_ptr to 0
        vld = 4'b1000; tg[3] = 6'h3F; dt[3] = 32'h0000_0001;
        step();
        vld = 4'b0000;
        step();
        chk("src3_valid", 64'(cdb_valid), 64'd1);
        chk("src3_src", 64'(cdb_src), 64'd3);
        step();

        // Contention: all four push at once
        vld = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tg[i] = 6'(i + 1);
            dt[i] = 32'h100 + 32'(i);
        end
        step();
        vld = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cont_valid", 64'(cdb_valid), 64'd1);
            chk("cont_tag", 64'(cdb_tag), 64'(k + 1));
            chk("cont_src", 64'(cdb_src), 64'(k));
        end
        step();
        chk("cont_idle", 64'(cdb_valid), 64'd0);

        // Backpressure: source 1 fills while source 0 holds priority
        vld = 4'b0011; tg[0] = 6'h30; dt[0] = 32'h3000; tg[1] = 6'h10; dt[1] = 32'h4000;
        step();
        step();
        chk("bp_grant_src0", 64'(bc_src), 64'd0);
        chk("bp_ready1_low", 64'(src_ready[1]), 64'd0);
        repeat (6) step();
        vld = 4'b0000;
        repeat (8) step();
        chk("bp_drain_src0", 64'(q[0].size()), 64'd0);
        chk("bp_drain_src1", 64'(q[1].size()), 64'd0);
        chk("bp_idle", 64'(cdb_valid), 64'd0);

        // Fairness: sources 0 and 2 stream continuously
        vld = 4'b0101; tg[0] = 6'h10; dt[0] = 32'h5000; tg[2] = 6'h20; dt[2] = 32'h6000;
        step();
        step();
        chk("rr_first_valid", 64'(bc_vld), 64'd1);
        prev = bc_src;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_tput", 64'(bc_vld), 64'd1);
            chk("rr_even_src", 64'(bc_src[0]), 64'd0);
            chk("rr_no_repeat", 64'(bc_src == prev), 64'd0);
            prev = bc_src;
        end
        vld = 4'b0000;
        repeat (6) step();
        chk("rr_drained", 64'(q[0].size() + q[2].size()), 64'd0);

        // Flush with three results queued plus a same-cycle push
        vld = 4'b0111; tg[0] = 6'h1A; tg[1] = 6'h1B; tg[2] = 6'h1C;
        step();
        chk("fl_pre_valid", 64'(cdb_valid), 64'd0);
        vld = 4'b1000; tg[3] = 6'h1D; flush = 1'b1;
        step();
        flush = 1'b0; vld = 4'b0000;
        chk("fl_valid", 64'(cdb_valid), 64'd0);
        chk("fl_ready", 64'(src_ready), 64'hf);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_no_bcast", 64'(cdb_valid), 64'd0);
        end

        // Asynchronous reset while a broadcast is on the bus
        vld = 4'b0011; tg[0] = 6'h0A; dt[0] = 32'hA; tg[1] = 6'h0B; dt[1] = 32'hB;
        step();
        vld = 4'b0000;
        step();
        chk("ar_pre_valid", 64'(cdb_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(cdb_valid), 64'd0);
        chk("ar_tag", 64'(cdb_tag), 64'd0);
        chk("ar_data", 64'(cdb_data), 64'd0);
        chk("ar_ready", 64'(src_ready), 64'hf);
        clear_q();
        #1 rst = 1'b0;
        vld = 4'b1000; tg[3] = 6'h2A; dt[3] = 32'h1234_5678;
        step();
        vld = 4'b0000;
        chk("ar_no_bypass", 64'(cdb_valid), 64'd0);
        step();
        chk("ar_post_valid", 64'(cdb_valid), 64'd1);
        chk("ar_post_src", 64'(cdb_src), 64'd3);
        chk("ar_post_tag", 64'(cdb_tag), 64'h2A);
        step();
        chk("ar_discarded", 64'(cdb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
